// File: rtl/instruction_fetch_controller.sv
// Byte-serial instruction fetch: assembles a big-endian word from a byte-wide memory,
// presents it with a valid/ready handshake, and follows branch redirects.
module instruction_fetch_controller #(
    parameter int          MEM_BYTES = 512,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] counter,
    output logic        fault,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        FAULT
    } state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] pc;
    logic [23:0] partial;
    logic        accept;
    logic [31:0] next_pc;
    logic        next_ok;

    assign mem_addr = (state == FETCH) ? pc + {30'd0, idx} : pc;
    assign accept   = (state == HOLD) && instr_ready;

    // A redirect always wins the next pc; otherwise only an acceptance advances it.
    assign next_pc  = redirect ? redirect_target : pc + 32'd4;
    assign next_ok  = (next_pc[1:0] == 2'b00) && (({1'b0, next_pc} + 33'd3) < MEM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            idx         <= 2'd0;
            pc          <= RESET_PC;
            partial     <= 24'd0;
            instr_valid <= 1'b0;
            instruction <= 32'd0;
            counter     <= 32'd0;
            fault       <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        idx <= 2'd0;
                        if (next_ok) begin
                            pc <= next_pc;
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end else if (idx == 2'd3) begin
                        instruction <= {partial, mem_data};
                        counter     <= pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                        idx         <= 2'd0;
                    end else begin
                        case (idx)
                            2'd0:    partial[23:16] <= mem_data;
                            2'd1:    partial[15:8]  <= mem_data;
                            default: partial[7:0]   <= mem_data;
                        endcase
                        idx <= idx + 2'd1;
                    end
                end
                HOLD: begin
                    // An accepted word is counted even when a redirect arrives with it.
                    if (accept || redirect) begin
                        instr_valid <= 1'b0;
                        if (accept) begin
                            instr_count <= instr_count + 16'd1;
                        end
                        if (next_ok) begin
                            pc    <= next_pc;
                            state <= FETCH;
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state       <= FAULT;
                    fault       <= 1'b1;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Randomised bench for instruction_fetch_controller: a transaction-level model predicts
// each presented word into a queue that an independent monitor checks against the DUT.
module tb_instruction_fetch_controller;

    localparam int          MEM_BYTES = 512;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] counter;
    logic        fault;
    logic [15:0] instr_count;

    logic [7:0]  mem [0:MEM_BYTES-1];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mpc;
    int          mcount;
    bit          mfault;

    instruction_fetch_controller #(
        .MEM_BYTES(MEM_BYTES),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .counter        (counter),
        .fault          (fault),
        .instr_count    (instr_count)
    );

    always #5 clk = ~clk;

    assign mem_data = (mem_addr < 32'(MEM_BYTES)) ? mem[mem_addr[8:0]] : 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] t);
        longint a = longint'(t);
        return (a % 4 == 0) && (a + 3 < MEM_BYTES);
    endfunction

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        int i = int'(a);
        return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic takeTarget(input logic [31:0] t);
        if (legal(t)) mpc = t;
        else          mfault = 1'b1;
    endtask

    task automatic checkReset();
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_instruction", instruction, 32'd0);
        checkOutput("rst_counter", counter, 32'd0);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("rst_count", {16'd0, instr_count}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, RESET_PC);
        mpc    = RESET_PC;
        mcount = 0;
        mfault = 1'b0;
        exp_q.delete();
    endtask

    // Leaves the DUT in the first cycle of a fresh fetch.
    task automatic doReset();
        reset = 1'b1;
        redirect = 1'b0;
        instr_ready = 1'b0;
        step();
        checkReset();
        reset = 1'b0;
    endtask

    // Faulted state must ignore redirect and ready entirely.
    task automatic checkFault();
        for (int c = 0; c < 3; c++) begin
            checkOutput("fault_flag", {31'd0, fault}, 32'd1);
            checkOutput("fault_valid", {31'd0, instr_valid}, 32'd0);
            checkOutput("fault_mem_addr", mem_addr, mpc);
            checkOutput("fault_count", {16'd0, instr_count}, 32'(mcount[15:0]));
            redirect = 1'(c);
            redirect_target = 32'h10;
            instr_ready = 1'b1;
            step();
        end
        redirect = 1'b0;
        instr_ready = 1'b0;
        doReset();
    endtask

    // One fetch transaction starting at byte index 0.
    // mode: 0 accept, 1 accept+redirect, 2 redirect in hold (discard), 3 reset in hold.
    task automatic applyStimulus(input int redir_idx, input logic [31:0] fetch_target,
                                 input int hold_cycles, input int mode, input logic [31:0] hold_target);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            checkOutput("fetch_addr", mem_addr, mpc + 32'(k));
            checkOutput("fetch_valid_low", {31'd0, instr_valid}, 32'd0);
            if (k == redir_idx) begin
                redirect = 1'b1;
                redirect_target = fetch_target;
                step();
                redirect = 1'b0;
                takeTarget(fetch_target);
                return;
            end
            step();
        end
        e.pc   = mpc;
        e.word = wordAt(mpc);
        e.cnt  = mcount[15:0];
        exp_q.push_back(e);
        checkOutput("valid_latency", {31'd0, instr_valid}, 32'd1);
        repeat (hold_cycles) step();
        redirect_target = hold_target;
        case (mode)
            0, 1: begin
                instr_ready = 1'b1;
                redirect = (mode == 1);
                step();
                instr_ready = 1'b0;
                redirect = 1'b0;
                mcount++;
                if (mode == 1) takeTarget(hold_target);
                else           takeTarget(mpc + 32'd4);
            end
            2: begin
                redirect = 1'b1;
                step();
                redirect = 1'b0;
                void'(exp_q.pop_front());
                takeTarget(hold_target);
            end
            default: begin
                reset = 1'b1;
                redirect = 1'b1;
                instr_ready = 1'b1;
                step();
                checkReset();
                reset = 1'b0;
                redirect = 1'b0;
                instr_ready = 1'b0;
            end
        endcase
    endtask

    // Monitor: every presented word must match the queue head; acceptance pops it.
    always @(negedge clk) begin
        if (!reset && instr_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                checkOutput("word", instruction, exp_q[0].word);
                checkOutput("counter", counter, exp_q[0].pc);
                if (instr_ready) begin
                    checkOutput("accept_count", {16'd0, instr_count}, {16'd0, exp_q[0].cnt});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r;
        int ridx;
        int mode;
        logic [31:0] tgt;
        logic [31:0] htgt;

        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h20; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h01;
        mpc = RESET_PC;
        mcount = 0;
        mfault = 1'b0;

        doReset();
        applyStimulus(-1, 32'd0, 0, 0, 32'd0);
        checkOutput("count_after_first", {16'd0, instr_count}, 32'd1);
        applyStimulus(-1, 32'd0, 10, 0, 32'd0);
        applyStimulus(2, 32'h80, 0, 0, 32'd0);
        applyStimulus(-1, 32'd0, 1, 0, 32'd0);
        applyStimulus(-1, 32'd0, 2, 2, 32'h40);
        applyStimulus(-1, 32'd0, 0, 1, 32'h100);
        applyStimulus(-1, 32'd0, 0, 0, 32'd0);

        applyStimulus(0, 32'h82, 0, 0, 32'd0);
        checkFault();
        applyStimulus(3, 32'h200, 0, 0, 32'd0);
        checkFault();
        applyStimulus(-1, 32'd0, 1, 2, 32'h1FD);
        checkFault();
        applyStimulus(1, 32'h1FC, 0, 0, 32'd0);
        applyStimulus(-1, 32'd0, 2, 0, 32'd0);
        checkFault();
        applyStimulus(-1, 32'd0, 3, 3, 32'h80);
        applyStimulus(-1, 32'd0, 0, 0, 32'd0);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 4)       tgt = 32'h82;
            else if (r < 7) tgt = 32'h200 + 32'($urandom_range(0, 3) * 4);
            else if (r < 12) tgt = 32'h1F8 + 32'($urandom_range(0, 1) * 4);
            else             tgt = 32'($urandom_range(0, 127) * 4);
            r = $urandom_range(0, 99);
            htgt = (r < 5) ? 32'h1FE : 32'($urandom_range(0, 127) * 4);
            ridx = ($urandom_range(0, 99) < 20) ? int'($urandom_range(0, 3)) : -1;
            r = $urandom_range(0, 99);
            mode = (r < 65) ? 0 : (r < 80) ? 1 : (r < 95) ? 2 : 3;
            applyStimulus(ridx, tgt, int'($urandom_range(0, 3)), mode, htgt);
            if (mfault) checkFault();
        end

        step();
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
